// File: rtl/exception_sequencer_if.sv
// Bundle of exception sources, CPSR view and sequencer outputs shared by the
// controller-side driver (master) and the exception sequencer (slave).
interface exception_sequencer_if;
  logic       IRQ;
  logic       FIQ;
  logic       UndefE;
  logic       SWIE;
  logic       PrefetchAbortE;
  logic       DataAbortM;
  logic [7:0] CPSRbits;
  logic       NotStallW;
  logic [5:0] ExceptionsE;
  logic       ExcFlush;
  logic       ExcBusy;
  logic       DropE;
  logic [5:0] PendingOut;

  modport master (
    output IRQ, FIQ, UndefE, SWIE, PrefetchAbortE, DataAbortM, CPSRbits, NotStallW,
    input  ExceptionsE, ExcFlush, ExcBusy, DropE, PendingOut
  );

  modport slave (
    input  IRQ, FIQ, UndefE, SWIE, PrefetchAbortE, DataAbortM, CPSRbits, NotStallW,
    output ExceptionsE, ExcFlush, ExcBusy, DropE, PendingOut
  );
endinterface

// File: rtl/exception_sequencer.sv
// Exception sequencer: synchronizes IRQ/FIQ, tracks pending sources with masking and
// same-mode suppression, and issues one exception at a time followed by a flush.
module exception_sequencer #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  exception_sequencer_if.slave bus
);

  localparam int B_UNDEF = 5;
  localparam int B_SWI   = 4;
  localparam int B_PABT  = 3;
  localparam int B_DABT  = 2;
  localparam int B_IRQ   = 1;
  localparam int B_FIQ   = 0;

  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;

  localparam int unsigned CNT_W        = (FLUSH_CYCLES > 32'd2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned FLUSH_LOAD_I = (FLUSH_CYCLES > 32'd1) ? (FLUSH_CYCLES - 32'd2) : 32'd0;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = FLUSH_LOAD_I[CNT_W-1:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Sticky sync sources {undef, swi, pabt, dabt}, each tagged by the mode it would enter.
  function automatic logic [5:2] same_mode(input logic [4:0] mode);
    same_mode = {mode == MODE_UND, mode == MODE_SVC, mode == MODE_ABT, mode == MODE_ABT};
  endfunction

  function automatic logic [5:0] pick_winner(input logic [5:0] en);
    logic [5:0] w;
    w = 6'b000000;
    if (en[B_DABT])       w[B_DABT]  = 1'b1;
    else if (en[B_FIQ])   w[B_FIQ]   = 1'b1;
    else if (en[B_IRQ])   w[B_IRQ]   = 1'b1;
    else if (en[B_PABT])  w[B_PABT]  = 1'b1;
    else if (en[B_UNDEF]) w[B_UNDEF] = 1'b1;
    else if (en[B_SWI])   w[B_SWI]   = 1'b1;
    else                  w = 6'b000000;
    return w;
  endfunction

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] irq_sync_q;
  logic [SYNC_STAGES-1:0] fiq_sync_q;
  logic [5:2]             sticky_q;
  logic [5:2]             sticky_d;
  logic [5:0]             winner_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [5:0]             exc_q;
  logic                   flush_q;
  logic                   busy_q;
  logic                   drop_q;

  logic [5:0] pending_s;
  logic [5:0] enabled_s;
  logic [5:0] select_s;
  logic       any_enabled_s;
  logic [5:2] drop_s;
  logic [5:2] clear_s;
  logic [5:2] set_s;
  logic       in_flush_s;
  logic       cpsr_t_unused_s;

  assign cpsr_t_unused_s = bus.CPSRbits[5];

  // Two-or-more flop synchronizers for the asynchronous interrupt levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_sync_q <= '0;
      fiq_sync_q <= '0;
    end else begin
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], bus.IRQ};
      fiq_sync_q <= {fiq_sync_q[SYNC_STAGES-2:0], bus.FIQ};
    end
  end

  // Pending/enabled vectors; pulses from instructions being flushed are discarded, dabt never is.
  always_comb begin
    pending_s     = {sticky_q, irq_sync_q[SYNC_STAGES-1], fiq_sync_q[SYNC_STAGES-1]};
    drop_s        = sticky_q & same_mode(bus.CPSRbits[4:0]);
    enabled_s     = {sticky_q & ~drop_s,
                     irq_sync_q[SYNC_STAGES-1] & ~bus.CPSRbits[7],
                     fiq_sync_q[SYNC_STAGES-1] & ~bus.CPSRbits[6]};
    select_s      = pick_winner(enabled_s);
    any_enabled_s = |enabled_s;
    in_flush_s    = (state_q == ST_ISSUE) || (state_q == ST_FLUSH);
    if (state_q == ST_ISSUE) begin
      clear_s = winner_q[5:2];
    end else begin
      clear_s = 4'b0000;
    end
    set_s    = {bus.UndefE & ~in_flush_s, bus.SWIE & ~in_flush_s,
                bus.PrefetchAbortE & ~in_flush_s, bus.DataAbortM};
    sticky_d = (sticky_q & ~drop_s & ~clear_s) | set_s;
  end

  // Sticky pending bits and the one-cycle drop indication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 4'b0000;
      drop_q   <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      drop_q   <= |drop_s;
    end
  end

  // Sequencer FSM; outputs are registered alongside the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      winner_q <= 6'b000000;
      cnt_q    <= '0;
      exc_q    <= 6'b000000;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      exc_q   <= 6'b000000;
      flush_q <= 1'b0;
      busy_q  <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (any_enabled_s) begin
            state_q <= ST_ARB;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_ARB: begin
          if (!any_enabled_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (bus.NotStallW) begin
            state_q  <= ST_ISSUE;
            winner_q <= select_s;
            exc_q    <= select_s;
            flush_q  <= 1'b1;
          end else begin
            state_q <= ST_ARB;
          end
        end
        ST_ISSUE: begin
          if (FLUSH_CYCLES > 32'd1) begin
            state_q <= ST_FLUSH;
            cnt_q   <= FLUSH_LOAD;
            flush_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
            flush_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ExceptionsE = exc_q;
  assign bus.ExcFlush    = flush_q;
  assign bus.ExcBusy     = busy_q;
  assign bus.DropE       = drop_q;
  assign bus.PendingOut  = pending_s;

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the sequencing rules.
module tb_exception_sequencer;
  localparam int SYNC = 2;
  localparam int FC   = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exception_sequencer_if bus();

  exception_sequencer #(.SYNC_STAGES(SYNC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Behavioural model state
  int         prio[6] = '{2, 0, 1, 3, 5, 4};
  logic [4:0] modes[4] = '{5'b10000, 5'b10011, 5'b11011, 5'b10111};
  logic [5:0] m_pend;
  bit         m_irq_q[$];
  bit         m_fiq_q[$];
  bit         m_arb;
  int         m_left;
  logic [5:0] m_win;
  logic [5:0] exp_exc, exp_pend;
  logic       exp_flush, exp_busy, exp_drop;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.IRQ = 1'b0; bus.FIQ = 1'b0; bus.UndefE = 1'b0; bus.SWIE = 1'b0;
    bus.PrefetchAbortE = 1'b0; bus.DataAbortM = 1'b0;
    bus.CPSRbits = 8'h10; bus.NotStallW = 1'b1;
  endtask

  function automatic logic [4:0] target_mode(int b);
    case (b)
      5:       return 5'b11011;
      4:       return 5'b10011;
      default: return 5'b10111;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 6'b0; m_arb = 1'b0; m_left = 0; m_win = 6'b0;
    m_irq_q = {}; m_fiq_q = {};
    for (int i = 0; i < SYNC; i++) begin
      m_irq_q.push_back(1'b0);
      m_fiq_q.push_back(1'b0);
    end
  endtask

  // One clock edge of the spec rules, using the inputs currently driven.
  task automatic model_step();
    logic [5:0] en, drop, clr;
    bit was_busy;
    int w;
    en = 6'b0; drop = 6'b0; clr = 6'b0; w = -1;
    for (int b = 2; b < 6; b++) begin
      if (m_pend[b]) begin
        if (bus.CPSRbits[4:0] == target_mode(b)) drop[b] = 1'b1;
        else en[b] = 1'b1;
      end
    end
    en[1] = m_irq_q[0] & ~bus.CPSRbits[7];
    en[0] = m_fiq_q[0] & ~bus.CPSRbits[6];
    was_busy = (m_left > 0);
    exp_exc = 6'b0;
    if (m_left > 0) begin
      if (m_left == FC) clr = m_win;
      m_left--;
    end else if (m_arb) begin
      if (en == 6'b0) m_arb = 1'b0;
      else if (bus.NotStallW) begin
        for (int k = 0; k < 6; k++) if (w < 0 && en[prio[k]]) w = prio[k];
        m_win = 6'b0;
        m_win[w] = 1'b1;
        exp_exc = m_win;
        m_left = FC;
        m_arb = 1'b0;
      end
    end else if (en != 6'b0) begin
      m_arb = 1'b1;
    end
    m_pend = m_pend & ~drop & ~clr & 6'b111100;
    if (bus.DataAbortM) m_pend[2] = 1'b1;
    if (!was_busy) begin
      if (bus.UndefE) m_pend[5] = 1'b1;
      if (bus.SWIE) m_pend[4] = 1'b1;
      if (bus.PrefetchAbortE) m_pend[3] = 1'b1;
    end
    m_irq_q.push_back(bus.IRQ); void'(m_irq_q.pop_front());
    m_fiq_q.push_back(bus.FIQ); void'(m_fiq_q.pop_front());
    exp_pend  = {m_pend[5:2], m_irq_q[0], m_fiq_q[0]};
    exp_drop  = |drop;
    exp_flush = (m_left > 0);
    exp_busy  = m_arb || (m_left > 0);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (bus.ExceptionsE !== 6'b0) begin errors++; $display("FAIL reset_exc got=%b exp=%b", bus.ExceptionsE, 6'b0); end
    checks++; if (bus.ExcFlush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", bus.ExcFlush); end
    checks++; if (bus.ExcBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.ExcBusy); end
    checks++; if (bus.DropE !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", bus.DropE); end
    checks++; if (bus.PendingOut !== 6'b0) begin errors++; $display("FAIL reset_pending got=%b exp=%b", bus.PendingOut, 6'b0); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_swi();
    idle_inputs();
    bus.SWIE = 1'b1; tick(); bus.SWIE = 1'b0;   // edge 0
    checks++; if (bus.PendingOut !== 6'b010000) begin errors++; $display("FAIL swi_pending got=%b exp=%b", bus.PendingOut, 6'b010000); end
    tick();                                       // edge 1: ARB
    checks++; if (bus.ExcBusy !== 1'b1 || bus.ExceptionsE !== 6'b0) begin errors++; $display("FAIL swi_arb busy=%b exc=%b exp busy=1 exc=0", bus.ExcBusy, bus.ExceptionsE); end
    tick();                                       // edge 2: ISSUE
    checks++; if (bus.ExceptionsE !== 6'b010000) begin errors++; $display("FAIL swi_issue got=%b exp=%b", bus.ExceptionsE, 6'b010000); end
    for (int e = 2; e < 5; e++) begin
      checks++; if (bus.ExcFlush !== 1'b1) begin errors++; $display("FAIL swi_flush edge%0d got=%b exp=1", e, bus.ExcFlush); end
      tick();
      if (e == 2) begin
        checks++; if (bus.ExceptionsE !== 6'b0 || bus.PendingOut !== 6'b0) begin errors++; $display("FAIL swi_after_issue exc=%b pend=%b exp 0", bus.ExceptionsE, bus.PendingOut); end
      end
    end
    checks++; if (bus.ExcFlush !== 1'b0 || bus.ExcBusy !== 1'b0) begin errors++; $display("FAIL swi_end flush=%b busy=%b exp 0 0", bus.ExcFlush, bus.ExcBusy); end
  endtask

  task automatic test_dabt_irq();
    idle_inputs();
    bus.IRQ = 1'b1; bus.DataAbortM = 1'b1; tick(); bus.DataAbortM = 1'b0;
    tick(); tick();
    checks++; if (bus.ExceptionsE !== 6'b000100) begin errors++; $display("FAIL dabt_first got=%b exp=%b", bus.ExceptionsE, 6'b000100); end
    bus.CPSRbits = 8'h90;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.ExceptionsE !== 6'b0) begin errors++; $display("FAIL irq_masked cyc%0d got=%b exp=0", i, bus.ExceptionsE); end
    end
    checks++; if (bus.PendingOut !== 6'b000010 || bus.ExcBusy !== 1'b0) begin errors++; $display("FAIL irq_held pend=%b busy=%b exp 000010 0", bus.PendingOut, bus.ExcBusy); end
    bus.CPSRbits = 8'h10;
    tick();
    checks++; if (bus.ExceptionsE !== 6'b0) begin errors++; $display("FAIL irq_unmask_arb got=%b exp=0", bus.ExceptionsE); end
    tick();
    checks++; if (bus.ExceptionsE !== 6'b000010) begin errors++; $display("FAIL irq_issue got=%b exp=%b", bus.ExceptionsE, 6'b000010); end
    bus.IRQ = 1'b0;
    for (int i = 0; i < 20 && bus.ExcBusy; i++) tick();
    checks++; if (bus.ExcBusy !== 1'b0) begin errors++; $display("FAIL irq_busy_timeout got=%b exp=0", bus.ExcBusy); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.ExceptionsE !== 6'b0) begin errors++; $display("FAIL irq_no_reissue cyc%0d got=%b exp=0", i, bus.ExceptionsE); end
    end
  endtask

  task automatic test_fiq_mask();
    idle_inputs();
    bus.CPSRbits = 8'h50;
    bus.FIQ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (bus.ExceptionsE !== 6'b0) begin errors++; $display("FAIL fiq_masked cyc%0d got=%b exp=0", i, bus.ExceptionsE); end
    end
    checks++; if (bus.PendingOut !== 6'b000001) begin errors++; $display("FAIL fiq_pending got=%b exp=%b", bus.PendingOut, 6'b000001); end
    bus.CPSRbits = 8'h10; bus.PrefetchAbortE = 1'b1; tick(); bus.PrefetchAbortE = 1'b0;
    for (int i = 0; i < 6 && bus.ExceptionsE == 6'b0; i++) tick();
    checks++; if (bus.ExceptionsE !== 6'b000001) begin errors++; $display("FAIL fiq_beats_pabt got=%b exp=%b", bus.ExceptionsE, 6'b000001); end
    bus.FIQ = 1'b0;
    tick();
    for (int i = 0; i < 12 && bus.ExceptionsE == 6'b0; i++) tick();
    checks++; if (bus.ExceptionsE !== 6'b001000) begin errors++; $display("FAIL pabt_after_fiq got=%b exp=%b", bus.ExceptionsE, 6'b001000); end
    for (int i = 0; i < 20 && bus.ExcBusy; i++) tick();
    checks++; if (bus.ExcBusy !== 1'b0) begin errors++; $display("FAIL fiq_busy_timeout got=%b exp=0", bus.ExcBusy); end
  endtask

  task automatic test_stall();
    idle_inputs();
    bus.NotStallW = 1'b0;
    bus.UndefE = 1'b1; tick(); bus.UndefE = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.ExceptionsE !== 6'b0 || bus.ExcBusy !== 1'b1) begin errors++; $display("FAIL stall_hold cyc%0d exc=%b busy=%b exp 0 1", i, bus.ExceptionsE, bus.ExcBusy); end
    end
    bus.NotStallW = 1'b1;
    tick();
    checks++; if (bus.ExceptionsE !== 6'b100000) begin errors++; $display("FAIL stall_release got=%b exp=%b", bus.ExceptionsE, 6'b100000); end
    for (int i = 0; i < 20 && bus.ExcBusy; i++) tick();
    checks++; if (bus.ExcBusy !== 1'b0) begin errors++; $display("FAIL stall_busy_timeout got=%b exp=0", bus.ExcBusy); end
  endtask

  task automatic test_drop_discard();
    idle_inputs();
    bus.CPSRbits = 8'h1B;
    bus.UndefE = 1'b1; tick(); bus.UndefE = 1'b0;
    checks++; if (bus.PendingOut !== 6'b100000) begin errors++; $display("FAIL drop_pending got=%b exp=%b", bus.PendingOut, 6'b100000); end
    tick();
    checks++; if (bus.DropE !== 1'b1 || bus.PendingOut !== 6'b0 || bus.ExcBusy !== 1'b0) begin errors++; $display("FAIL drop_pulse drop=%b pend=%b busy=%b exp 1 0 0", bus.DropE, bus.PendingOut, bus.ExcBusy); end
    tick();
    checks++; if (bus.DropE !== 1'b0) begin errors++; $display("FAIL drop_one_cycle got=%b exp=0", bus.DropE); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.ExceptionsE !== 6'b0) begin errors++; $display("FAIL drop_no_issue cyc%0d got=%b exp=0", i, bus.ExceptionsE); end
    end
    bus.CPSRbits = 8'h10;
    bus.DataAbortM = 1'b1; tick(); bus.DataAbortM = 1'b0;
    for (int i = 0; i < 6 && bus.ExceptionsE == 6'b0; i++) tick();
    checks++; if (bus.ExceptionsE !== 6'b000100) begin errors++; $display("FAIL discard_dabt got=%b exp=%b", bus.ExceptionsE, 6'b000100); end
    tick();
    bus.SWIE = 1'b1; tick(); bus.SWIE = 1'b0;
    checks++; if (bus.PendingOut !== 6'b0 || bus.ExcFlush !== 1'b1) begin errors++; $display("FAIL swi_discarded pend=%b flush=%b exp 000000 1", bus.PendingOut, bus.ExcFlush); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.ExceptionsE !== 6'b0) begin errors++; $display("FAIL discard_no_issue cyc%0d got=%b exp=0", i, bus.ExceptionsE); end
    end
  endtask

  task automatic test_reset_mid_flush();
    idle_inputs();
    bus.DataAbortM = 1'b1; tick(); bus.DataAbortM = 1'b0;
    for (int i = 0; i < 6 && bus.ExceptionsE == 6'b0; i++) tick();
    tick();
    bus.DataAbortM = 1'b1; tick(); bus.DataAbortM = 1'b0;
    checks++; if (bus.PendingOut !== 6'b000100 || bus.ExcFlush !== 1'b1) begin errors++; $display("FAIL dabt_in_flush pend=%b flush=%b exp 000100 1", bus.PendingOut, bus.ExcFlush); end
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.ExceptionsE, bus.ExcFlush, bus.ExcBusy, bus.DropE, bus.PendingOut} !== 15'b0) begin
      errors++; $display("FAIL async_reset exc=%b flush=%b busy=%b drop=%b pend=%b exp all 0", bus.ExceptionsE, bus.ExcFlush, bus.ExcBusy, bus.DropE, bus.PendingOut);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.ExceptionsE !== 6'b0 || bus.ExcBusy !== 1'b0) begin errors++; $display("FAIL post_reset cyc%0d exc=%b busy=%b exp 0 0", i, bus.ExceptionsE, bus.ExcBusy); end
    end
  endtask

  task automatic test_random();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    model_reset();
    reset_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(39, 0) == 0)
        bus.CPSRbits = {1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0, modes[$urandom_range(3, 0)]};
      if ($urandom_range(15, 0) == 0) bus.IRQ = ~bus.IRQ;
      if ($urandom_range(15, 0) == 0) bus.FIQ = ~bus.FIQ;
      bus.UndefE         = ($urandom_range(7, 0) == 0);
      bus.SWIE           = ($urandom_range(7, 0) == 0);
      bus.PrefetchAbortE = ($urandom_range(7, 0) == 0);
      bus.DataAbortM     = ($urandom_range(9, 0) == 0);
      bus.NotStallW      = ($urandom_range(3, 0) != 0);
      model_step();
      tick();
      checks++; if (bus.ExceptionsE !== exp_exc) begin errors++; $display("FAIL rnd_exc cyc%0d got=%b exp=%b", c, bus.ExceptionsE, exp_exc); end
      checks++; if (bus.PendingOut !== exp_pend) begin errors++; $display("FAIL rnd_pending cyc%0d got=%b exp=%b", c, bus.PendingOut, exp_pend); end
      checks++; if (bus.ExcFlush !== exp_flush) begin errors++; $display("FAIL rnd_flush cyc%0d got=%b exp=%b", c, bus.ExcFlush, exp_flush); end
      checks++; if (bus.ExcBusy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc%0d got=%b exp=%b", c, bus.ExcBusy, exp_busy); end
      checks++; if (bus.DropE !== exp_drop) begin errors++; $display("FAIL rnd_drop cyc%0d got=%b exp=%b", c, bus.DropE, exp_drop); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_swi();
    test_dabt_irq();
    test_fiq_mask();
    test_stall();
    test_drop_discard();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
